seg_scan_controller: RTL and testbench



---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_decode.sv | 36 +++
 rtl/seg_scan_controller.sv | 139 +++++++++++++
 tb/tb_seg_scan_controller.sv | 128 ++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment bit positions,
// active-high glyph patterns {dp,g,f,e,d,c,b,a} and the scan FSM state type.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } seg_state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD digit + decimal point to active-high segment pattern.
// Non-decimal codes render as a dash; blank_i suppresses a-g but keeps dp.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] glyph;

  always_comb begin
    glyph = GLYPH_DASH;
    case (bcd_i)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_DASH;
    endcase
    if (blank_i) begin
      glyph = GLYPH_BLANK;
    end
    seg_o         = glyph;
    seg_o[SEG_DP] = dp_i;
  end

endmodule

// File: rtl/seg_scan_controller.sv
// 4-digit common-anode scan controller: guard/ON sequencing, per-frame input
// snapshot, 16-level PWM. Define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_BCD,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_brightness,
  output logic [3:0]  o_digitSelect,
  output logic [7:0]  o_LED,
  output logic        o_frame_done
);

  localparam int CW = $clog2((DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES);
  localparam logic [CW-1:0] ON_LAST    = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

  seg_state_e    state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    pwm_q, pwm_d;
  logic [15:0]   snap_bcd_q, snap_bcd_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic [3:0]    snap_bright_q, snap_bright_d;
  logic          last_q, last_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    led_q, led_d;
  logic          done_q;

  logic          lead_zero;
  logic          lit;
  logic [7:0]    seg;

  // Sequencer: snapshot is taken only when entering digit 0, so a frame never tears.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q + 1'b1;
    digit_d       = digit_q;
    pwm_d         = pwm_q;
    snap_bcd_d    = snap_bcd_q;
    snap_dp_d     = snap_dp_q;
    snap_bright_d = snap_bright_q;
    last_d        = 1'b0;
    case (state_q)
      ST_GUARD: begin
        if (phase_q == GUARD_LAST) begin
          state_d = ST_ON;
          phase_d = '0;
          pwm_d   = '0;
          if (digit_q == 2'd0) begin
            snap_bcd_d    = i_BCD;
            snap_dp_d     = i_dp;
            snap_bright_d = i_brightness;
          end
        end
      end
      ST_ON: begin
        pwm_d = pwm_q + 4'd1;
        if (phase_q == ON_LAST) begin
          state_d = ST_GUARD;
          phase_d = '0;
          digit_d = digit_q + 2'd1;
          last_d  = (digit_q == 2'd3);
        end
      end
      default: state_d = ST_GUARD;
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    lead_zero = 1'b0;
    case (digit_q)
      2'd3:    lead_zero = (snap_bcd_q[15:12] == 4'd0);
      2'd2:    lead_zero = (snap_bcd_q[15:8] == 8'd0);
      2'd1:    lead_zero = (snap_bcd_q[15:4] == 12'd0);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  seg_decode u_decode (
    .bcd_i   (snap_bcd_q[{digit_q, 2'b00} +: 4]),
    .dp_i    (snap_dp_q[digit_q]),
    .blank_i (lead_zero),
    .seg_o   (seg)
  );

  // Output registers follow the current state, so they lag the state by one cycle.
  always_comb begin
    lit   = (state_q == ST_ON) && ((snap_bright_q == 4'hF) || (pwm_q < snap_bright_q));
    sel_d = 4'hF;
    led_d = 8'hFF;
    if (lit) begin
      sel_d = ~(4'b0001 << digit_q);
      led_d = ~seg;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q       <= ST_GUARD;
      phase_q       <= '0;
      digit_q       <= 2'd0;
      pwm_q         <= 4'd0;
      snap_bcd_q    <= 16'd0;
      snap_dp_q     <= 4'd0;
      snap_bright_q <= 4'd0;
      last_q        <= 1'b0;
      sel_q         <= 4'hF;
      led_q         <= 8'hFF;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      digit_q       <= digit_d;
      pwm_q         <= pwm_d;
      snap_bcd_q    <= snap_bcd_d;
      snap_dp_q     <= snap_dp_d;
      snap_bright_q <= snap_bright_d;
      last_q        <= last_d;
      sel_q         <= sel_d;
      led_q         <= led_d;
      done_q        <= last_q;
    end
  end

  assign o_digitSelect = sel_q;
  assign o_LED         = led_q;
  assign o_frame_done  = done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with DIGIT_CYCLES=16, GUARD_CYCLES=2;
// each frame is checked cycle by cycle against hand-computed LED patterns.
module tb_seg_scan_controller;

  localparam int DC = 16;
  localparam int GC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [3:0]  bright;
  logic [3:0]  sel;
  logic [7:0]  led;
  logic        done;

  logic [12:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Active-low LED patterns {digit3, digit2, digit1, digit0}
  localparam logic [31:0] L1234 = {8'hF9, 8'h24, 8'hB0, 8'h99};
  localparam logic [31:0] L9999 = {8'h90, 8'h90, 8'h90, 8'h90};
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [31:0] L00A5 = {8'h7F, 8'hFF, 8'hBF, 8'h92};
  localparam logic [31:0] L0000 = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
`else
  localparam logic [31:0] L00A5 = {8'h40, 8'hC0, 8'hBF, 8'h92};
  localparam logic [31:0] L0000 = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif

  always #5 clk = ~clk;

  seg_scan_controller #(
    .DIGIT_CYCLES (DC),
    .GUARD_CYCLES (GC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_BCD         (bcd),
    .i_dp          (dp),
    .i_brightness  (bright),
    .o_digitSelect (sel),
    .o_LED         (led),
    .o_frame_done  (done)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_val({name, "/rst_sel"}, 8'(sel), 8'h0F);
      check_val({name, "/rst_led"}, led, 8'hFF);
      check_val({name, "/rst_done"}, 8'(done), 8'h00);
    end
  endtask

  // Checks one full frame starting at the first guard cycle of digit 0.
  task automatic run_frame(input string name, input logic [31:0] leds, input logic [3:0] br,
                           input bit first, input bit chg, input logic [15:0] chg_bcd);
    logic [12:0] e;
    logic [3:0]  s;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < GC; c++)
        exp_q.push_back({(d == 0 && c == 0 && !first), 4'hF, 8'hFF});
      s = ~(4'b0001 << d);
      for (int j = 0; j < DC; j++) begin
        if (br == 4'hF || j < int'(br)) exp_q.push_back({1'b0, s, leds[d*8 +: 8]});
        else                            exp_q.push_back({1'b0, 4'hF, 8'hFF});
      end
    end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < GC + DC; c++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        check_val($sformatf("%s/d%0d/c%0d/sel", name, d, c), 8'(sel), 8'(e[11:8]));
        check_val($sformatf("%s/d%0d/c%0d/led", name, d, c), led, e[7:0]);
        check_val($sformatf("%s/d%0d/c%0d/done", name, d, c), 8'(done), 8'(e[12]));
        if (chg && d == 1 && c == GC + 5) bcd = chg_bcd;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    bcd    = 16'h1234;
    dp     = 4'b0100;
    bright = 4'hF;
    check_reset("init", 3);
    rst_n = 1'b1;

    run_frame("b15_f0", L1234, 4'hF, 1'b1, 1'b0, 16'h0);
    run_frame("b15_f1", L1234, 4'hF, 1'b0, 1'b0, 16'h0);

    bright = 4'd4;
    run_frame("b4", L1234, 4'd4, 1'b0, 1'b0, 16'h0);
    bright = 4'd0;
    run_frame("b0", L1234, 4'd0, 1'b0, 1'b0, 16'h0);

    bright = 4'hF;
    dp     = 4'b0000;
    run_frame("tear_f0", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF, 1'b0, 1'b1, 16'h9999);
    run_frame("tear_f1", L9999, 4'hF, 1'b0, 1'b0, 16'h0);

    for (int i = 0; i < GC + 3; i++) @(negedge clk);
    rst_n = 1'b0;
    bcd   = 16'h00A5;
    dp    = 4'b1000;
    check_reset("midrst", 3);
    rst_n = 1'b1;
    run_frame("dash", L00A5, 4'hF, 1'b1, 1'b0, 16'h0);

    bcd = 16'h0000;
    dp  = 4'b0000;
    run_frame("zero", L0000, 4'hF, 1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
